// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial pattern detector with Mealy match strobe
// Optional match counter built only when SEQ_DET_CNT_EN is defined.
module seq_detect_prog #(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 16,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'b0000_1011),
    parameter int               RST_LEN = 4,
    parameter logic             RST_OVL = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       en_i,
    input  logic                       seq_vld_i,
    input  logic                       seq_i,
    input  logic                       cfg_load_i,
    input  logic [PAT_W-1:0]           cfg_pat_i,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len_i,
    input  logic                       cfg_ovl_i,
    output logic                       match_o,
    output logic [CNT_W-1:0]           match_cnt_o,
    output logic [1:0]                 state_o
);
    localparam int LW = $clog2(PAT_W + 1);
    localparam int FW = $clog2(PAT_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [LW-1:0]    len_q;
    logic             ovl_q;
    logic [PAT_W-2:0] hist_q;
    logic [FW-1:0]    fill_q;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic             fill_ok;
    logic [LW-1:0]    len_clamped;

    assign window      = {hist_q, seq_i};
    assign len_clamped = (cfg_len_i > LW'(PAT_W)) ? LW'(PAT_W) : cfg_len_i;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_q));
        end
        // The len_q-1 oldest compared bits must all be real history, not leftovers.
        fill_ok = (int'(fill_q) + 1) >= int'(len_q);
    end

    assign match_o = (state_q == RUN) && seq_vld_i && !cfg_load_i && (len_q != '0)
                     && fill_ok && (((window ^ pat_q) & mask) == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RUN;
            pat_q   <= RST_PAT;
            len_q   <= LW'(RST_LEN);
            ovl_q   <= RST_OVL;
            hist_q  <= '0;
            fill_q  <= '0;
        end else if (cfg_load_i) begin
            pat_q   <= cfg_pat_i;
            len_q   <= len_clamped;
            ovl_q   <= cfg_ovl_i;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= FLUSH;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_i) state_q <= RUN;
                end
                RUN: begin
                    if (seq_vld_i) begin
                        if (match_o && !ovl_q) begin
                            fill_q <= '0;
                        end else begin
                            hist_q <= window[PAT_W-2:0];
                            if (fill_q != FW'(PAT_W - 1)) fill_q <= fill_q + FW'(1);
                        end
                    end
                    if (!en_i) state_q <= IDLE;
                end
                FLUSH: begin
                    hist_q  <= '0;
                    fill_q  <= '0;
                    state_q <= en_i ? RUN : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o = state_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (cfg_load_i) begin
            cnt_q <= '0;
        end else if (match_o && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt_o = cnt_q;
`else
    assign match_cnt_o = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - randomized and directed bench for seq_detect_prog against a queue-based model
module tb_seq_detect_prog;
    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SEQ_DET_CNT_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b1;
    logic             vld = 1'b0;
    logic             seq = 1'b0;
    logic             load = 1'b0;
    logic [PAT_W-1:0] cp = '0;
    logic [3:0]       cl = '0;
    logic             co = 1'b0;
    logic             match_o;
    logic [CNT_W-1:0] match_cnt_o;
    logic [1:0]       state_o;

    int vectors = 0;
    int miscompares = 0;

    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .seq_vld_i(vld), .seq_i(seq),
        .cfg_load_i(load), .cfg_pat_i(cp), .cfg_len_i(cl), .cfg_ovl_i(co),
        .match_o(match_o), .match_cnt_o(match_cnt_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 running, 2 flushing; hist holds only the valid received bits, newest last.
    int       m_mode, m_len, m_cnt;
    bit [7:0] m_pat;
    bit       m_ovl;
    bit       hist[$];

    function automatic void m_reset();
        m_mode = 1; m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1; m_cnt = 0;
        hist.delete();
    endfunction

    function automatic bit m_match();
        bit b;
        if (m_mode != 1 || !vld || load || m_len == 0) return 1'b0;
        if (hist.size() < m_len - 1) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            b = (i == 0) ? seq : hist[hist.size() - i];
            if (b != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void m_push(input bit b);
        hist.push_back(b);
        if (hist.size() > PAT_W - 1) void'(hist.pop_front());
    endfunction

    always @(negedge clk) begin
        bit em;
        if (!rst_n) begin
            m_reset();
            chk("rst_match", int'(match_o), 0);
            chk("rst_state", int'(state_o), 1);
            chk("rst_cnt", int'(match_cnt_o), 0);
        end else begin
            em = m_match();
            chk("match", int'(match_o), int'(em));
            chk("state", int'(state_o), m_mode);
            chk("cnt", int'(match_cnt_o), HAS_CNT ? m_cnt : 0);
            if (load) begin
                m_pat = cp; m_len = (cl > PAT_W) ? PAT_W : int'(cl); m_ovl = co;
                m_cnt = 0; hist.delete(); m_mode = 2;
            end else begin
                case (m_mode)
                    0: if (en) m_mode = 1;
                    1: begin
                        if (vld) begin
                            if (em) begin
                                if (m_cnt < CMAX) m_cnt++;
                                if (m_ovl) m_push(seq); else hist.delete();
                            end else m_push(seq);
                        end
                        if (!en) m_mode = 0;
                    end
                    default: begin hist.delete(); m_mode = en ? 1 : 0; end
                endcase
            end
        end
    end

    task automatic tick(input logic v, input logic s);
        @(posedge clk); #1;
        vld = v; seq = s; load = 1'b0;
    endtask

    task automatic load_cfg(input logic [7:0] p, input logic [3:0] ln, input logic o);
        @(posedge clk); #1;
        vld = 1'b0; load = 1'b1; cp = p; cl = ln; co = o;
        tick(1'b0, 1'b0);
    endtask

    // bits are sent MSB first; mask bit i is the strobe seen on the i-th bit sent
    task automatic send(input logic [31:0] bits, input int n, input bit gap, output logic [31:0] mask);
        mask = '0;
        for (int i = 0; i < n; i++) begin
            tick(1'b1, bits[n-1-i]);
            @(negedge clk);
            mask[i] = match_o;
            if (gap) tick(1'b0, 1'($urandom));
        end
        tick(1'b0, 1'b0);
    endtask

    logic [31:0] mk, mk2;
    int r;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state_literal", int'(state_o), 1);

        send(32'b1011011, 7, 1'b0, mk);
        chk("legacy_1011_mask", mk, 32'h48);
        @(negedge clk);
        chk("legacy_cnt", int'(match_cnt_o), HAS_CNT ? 2 : 0);

        load_cfg(8'h0B, 4'd4, 1'b0);
        send(32'b10110111011, 11, 1'b0, mk);
        chk("nonovl_1011_mask", mk, 32'h408);

        load_cfg(8'h03, 4'd2, 1'b1);
        send(32'b1111, 4, 1'b0, mk);
        chk("ovl_11_mask", mk, 32'hE);
        load_cfg(8'h03, 4'd2, 1'b0);
        send(32'b1111, 4, 1'b0, mk);
        chk("nonovl_11_mask", mk, 32'hA);

        load_cfg(8'hA5, 4'd8, 1'b1);
        send(32'b1010, 4, 1'b1, mk);
        @(posedge clk); #1 en = 1'b0; vld = 1'b0;
        @(posedge clk); #1 vld = 1'b1; seq = 1'($urandom);
        @(posedge clk); #1 seq = 1'($urandom);
        @(posedge clk); #1 en = 1'b1; seq = 1'($urandom);
        send(32'b0101, 4, 1'b1, mk2);
        chk("a5_first_half", mk, 0);
        chk("a5_second_half", mk2, 32'h8);

        load_cfg(8'h0B, 4'd4, 1'b1);
        send(32'b1011, 4, 1'b0, mk);
        send(32'b01, 2, 1'b0, mk2);
        @(negedge clk);
        chk("pre_load_cnt", int'(match_cnt_o), HAS_CNT ? 1 : 0);
        @(posedge clk); #1;
        vld = 1'b1; seq = 1'b1; load = 1'b1; cp = 8'h0B; cl = 4'd4; co = 1'b1;
        @(negedge clk);
        chk("coincident_load_match", int'(match_o), 0);
        tick(1'b0, 1'b0);
        @(negedge clk);
        chk("coincident_load_cnt", int'(match_cnt_o), 0);

        load_cfg(8'hFF, 4'd12, 1'b1);
        send(32'h3FF, 10, 1'b0, mk);
        chk("len_clamp_mask", mk, 32'h380);

        load_cfg(8'h00, 4'd0, 1'b1);
        send(32'h0, 16, 1'b0, mk);
        chk("len0_mask", mk, 0);

        load_cfg(8'h0B, 4'd4, 1'b1);
        send(32'b1011011011011011, 16, 1'b0, mk);
        chk("sat_mask", mk, 32'h9248);
        @(negedge clk);
        chk("sat_cnt", int'(match_cnt_o), HAS_CNT ? 3 : 0);

        load_cfg(8'h06, 4'd4, 1'b0);
        send(32'b101, 3, 1'b0, mk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_state", int'(state_o), 1);
        chk("midrst_cnt", int'(match_cnt_o), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        send(32'b1011, 4, 1'b0, mk);
        chk("post_rst_mask", mk, 32'h8);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            r     = $urandom_range(0, 999);
            rst_n = !(r < 3);
            load  = (r >= 3 && r < 30);
            en    = ($urandom_range(0, 9) != 0);
            vld   = ($urandom_range(0, 3) != 0);
            seq   = 1'($urandom);
            cp    = 8'($urandom);
            cl    = 4'($urandom_range(0, 10));
            co    = 1'($urandom);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; load = 1'b0; vld = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable, parametrised serial pattern detector; the next-generation replacement for the fixed 4-bit "1011" Mealy detector. It matches a runtime-loaded pattern of 1..PAT_W bits on a qualified serial stream, with selectable overlapping or non-overlapping detection and a saturating match counter. It sits on serial front-end paths (framing/sync-word search) and drives a single-cycle Mealy match strobe to downstream control.

## Interface
- PAT_W, 8, maximum pattern length in bits (>= 2)
- CNT_W, 16, match counter width
- RST_PAT, 8'b0000_1011, pattern after reset, LSB = last bit received
- RST_LEN, 4, pattern length after reset
- RST_OVL, 1, overlap mode after reset

- clk_i  input  1  clock
- rst_n_i  input  1  reset, asynchronous, active-low
- en_i  input  1  detector enable
- seq_vld_i  input  1  serial bit qualifier
- seq_i  input  1  serial bit
- cfg_load_i  input  1  one-cycle strobe; latch cfg_* fields
- cfg_pat_i  input  PAT_W  pattern; bit 0 = last bit of sequence
- cfg_len_i  input  $clog2(PAT_W+1)  pattern length
- cfg_ovl_i  input  1  1 = overlapping, 0 = non-overlapping
- match_o  output  1  Mealy match strobe
- match_cnt_o  output  CNT_W  saturating match count
- state_o  output  2  current FSM state (for debug)

## Operation
- Registers: pat_q, len_q, ovl_q (configuration); hist_q (PAT_W-1 bits, shift-in at LSB); fill_q (number of valid history bits, saturating at PAT_W-1); cnt_q.
- FSM states: IDLE=2'd0, RUN=2'd1, FLUSH=2'd2.
  - IDLE: en_i=0. Bits are ignored; hist_q/fill_q are held; match_o=0. en_i=1 -> RUN.
  - RUN: on each seq_vld_i, shift seq_i into hist_q and increment fill_q (saturating). en_i=0 -> IDLE.
  - FLUSH: entered for one cycle after cfg_load_i. Clears hist_q and fill_q. Bits arriving in this cycle are discarded. Then -> RUN if en_i=1, otherwise -> IDLE.
- Match condition, evaluated in RUN: seq_vld_i && len_q != 0 && fill_q >= len_q-1 && lower len_q bits of {hist_q, seq_i} == lower len_q bits of pat_q.
- On a match:
  - ovl_q=1: history is kept, so overlapping matches are found.
  - ovl_q=0: fill_q is cleared to 0 and the current bit is not retained as history; detection restarts from scratch.
- len_q=0: matching is disabled. len values above PAT_W are clamped to PAT_W on load. Pattern bits above len_q are don't-care.
- cfg_load_i:
  - Accepted in any state. Latches pat/len/ovl and clears cnt_q.
  - It takes priority over a simultaneous seq_vld_i; that bit is dropped and no match is raised.
- match_cnt_o increments on every match and saturates at all-ones.

## Timing
- Reset values:
  - state = RUN.
  - pat_q=RST_PAT, len_q=RST_LEN, ovl_q=RST_OVL.
  - hist_q=0, fill_q=0, cnt_q=0.
  - match_o=0, match_cnt_o=0, state_o=2'd1.
- Because reset enters RUN, out-of-reset behaviour equals the legacy 1011 overlapping detector.
- Reset asserted mid-stream aborts the partial match immediately and restores the reset configuration.
- match_o is combinational and asserts in the same cycle as the final pattern bit (zero latency). It is high for exactly one cycle per qualifying bit.
- match_cnt_o updates on the clock edge ending the match cycle, so it is visible 1 cycle after match_o.
- New configuration takes effect for bits qualified 2 cycles after cfg_load_i, i.e. the cycle after FLUSH.
- en_i deassertion takes effect at the next edge. In the cycle en_i falls while in RUN, a match can still fire.

## Configuration
- SEQ_DET_CNT_EN:
  - Defined: cnt_q and its saturation logic are built; match_cnt_o is as specified.
  - Undefined: no counter flops are built; match_cnt_o is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset defaults, en_i=1, stream 1,0,1,1,0,1,1 -> match_o on bits 4 and 7; match_cnt_o=2.
- Load pat=1011, len=4, ovl=0, then stream 1,0,1,1,0,1,1,1,0,1,1 -> match_o on bits 4 and 11 only; the overlap at bit 7 is suppressed.
- Load pat=11, len=2, then stream 1,1,1,1 -> ovl=1 gives 3 matches (bits 2,3,4); ovl=0 gives 2 matches (bits 2,4).
- Load len=8, pat=8'hA5, stream 0xA5 MSB-first with seq_vld_i gaps and en_i toggled low for 3 cycles mid-stream -> single match on the last bit; gaps and IDLE cycles do not break the match.
- cfg_load_i coincident with the final bit of a would-be match -> no match_o, counter cleared; len=0 load -> no matches on any stream.
- With SEQ_DET_CNT_EN defined and CNT_W=2, drive 5 matches -> match_cnt_o saturates at 3; assert rst_n_i mid-pattern -> all outputs at reset values and the next 1011 matches normally.
